// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: PC width, reset PC default,
// sequencer FSM states and the PC next-value source select.
package pc_sequencer_pkg;

    localparam int PC_W = 8;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_HALT
    } seq_state_e;

    // Where the PC is loaded from on the next edge.
    typedef enum logic [1:0] {
        SRC_KEEP,
        SRC_INC,
        SRC_TARGET,
        SRC_RAS
    } pc_src_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between the PC sequencer (master) and
// instruction memory (slave).
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic fetch_valid;
    logic fetch_ready;
    pc_t  fetch_addr;

    modport master (
        output fetch_valid,
        output fetch_addr,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_addr,
        output fetch_ready
    );

endinterface

// File: rtl/pc_sequencer_ret_addr_stack.sv
// Return-address LIFO for call/return redirects. Push and pop are ignored
// when full or empty respectively; the caller reports the error.
module ret_addr_stack
    import pc_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  logic pop_i,
    input  pc_t  din_i,
    output pc_t  dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] top_ptr;
    logic [CNT_W-1:0] wr_ptr;
    logic             do_push, do_pop;
    pc_t              mem_q [DEPTH];

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign top_ptr = count_q - CNT_W'(1);
    assign wr_ptr  = do_pop ? top_ptr : count_q;
    assign dout_o  = mem_q[top_ptr[IDX_W-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = top_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only ever read after being pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr[IDX_W-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/HOLD/HALT fetch FSM with branch,
// call and return redirects. Define RAS_EN to compile in the return-address stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter pc_t RESET_PC  = RESET_PC_DEF,
    parameter int  RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic           stall,
    input  logic           halt,
    input  logic           branch_en,
    input  logic           call_en,
    input  logic           ret_en,
    input  pc_t            branch_addr,
    output pc_t            pc_o,
    input  pc_t            inc_i,
    pc_sequencer_if.master fetch,
    output logic           wrap_o,
    output logic           ras_err
);

    seq_state_e state_q, state_d;
    pc_t        pc_q, pc_d;
    pc_src_e    pc_src;
    logic       wrap_q;
    logic       wrap_set;
    logic       valid_w;
    logic       handshake;
    logic       active;

    assign valid_w           = (state_q == ST_FETCH);
    assign fetch.fetch_valid = valid_w;
    assign fetch.fetch_addr  = pc_q;
    assign pc_o              = pc_q;
    assign wrap_o            = wrap_q;
    assign handshake         = valid_w & fetch.fetch_ready;
    // Redirects are taken in FETCH or HOLD unless halt wins the cycle.
    assign active            = ((state_q == ST_FETCH) || (state_q == ST_HOLD)) && !halt;

`ifdef RAS_EN
    logic ras_push, ras_pop, ras_full, ras_empty;
    logic ras_err_q, ras_err_set;
    pc_t  ras_dout;

    ret_addr_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .din_i   (inc_i),
        .dout_o  (ras_dout),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    assign ras_err = ras_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_err_q <= 1'b0;
        end else if (ras_err_set) begin
            ras_err_q <= 1'b1;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = &{1'b0, ret_en, RAS_DEPTH[0]};
    assign ras_err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_FETCH;
            ST_FETCH,
            ST_HOLD: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_src = SRC_KEEP;
`ifdef RAS_EN
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_err_set = 1'b0;
`endif
        if (active) begin
`ifdef RAS_EN
            if (ret_en) begin
                // Underflow falls through to the next sequential address.
                if (ras_empty) begin
                    pc_src      = SRC_INC;
                    ras_err_set = 1'b1;
                end else begin
                    pc_src  = SRC_RAS;
                    ras_pop = 1'b1;
                end
            end else if (call_en) begin
                pc_src = SRC_TARGET;
                if (ras_full) begin
                    ras_err_set = 1'b1;
                end else begin
                    ras_push = 1'b1;
                end
            end else if (branch_en) begin
                pc_src = SRC_TARGET;
            end else if (handshake) begin
                pc_src = SRC_INC;
            end
`else
            if (call_en || branch_en) begin
                pc_src = SRC_TARGET;
            end else if (handshake) begin
                pc_src = SRC_INC;
            end
`endif
        end else if (handshake) begin
            // A fetch accepted in the halting cycle still moves the PC past it.
            pc_src = SRC_INC;
        end
    end

    always_comb begin
        case (pc_src)
            SRC_INC:    pc_d = inc_i;
            SRC_TARGET: pc_d = branch_addr;
`ifdef RAS_EN
            SRC_RAS:    pc_d = ras_dout;
`endif
            default:    pc_d = pc_q;
        endcase
    end

    assign wrap_set = (pc_src == SRC_INC) && (pc_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (wrap_set) begin
                wrap_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 8-bit RISC processor. It holds the architectural PC, drives it to the `Adder` incrementer (`PCa`) and takes the incremented value (`inca`) back, then offers the fetch address to instruction memory with a valid/ready handshake. It also handles branch, call and return redirects, stalls and halt. It sits between the control unit and the instruction-fetch port.

## Interface
Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (2..8); used only when the stack is compiled in.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- run  in  1  leave IDLE and start fetching.
- stall  in  1  suspend fetch offers.
- halt  in  1  stop sequencing permanently until reset.
- branch_en  in  1  redirect PC to branch_addr.
- call_en  in  1  call redirect to branch_addr.
- ret_en  in  1  return redirect.
- branch_addr  in  8  branch/call target.
- pc_o  out  8  current PC, wired to Adder `PCa`.
- inc_i  in  8  PC+1 from Adder `inca`; combinational from pc_o.
- fetch_valid  out  1  fetch address offered.
- fetch_ready  in  1  instruction memory accepts.
- fetch_addr  out  8  equal to pc_o.
- wrap_o  out  1  sticky; set when PC advanced 8'hFF -> 8'h00.
- ras_err  out  1  sticky stack overflow/underflow flag.

## Operation
- FSM states: IDLE, FETCH, HOLD, HALT. Reset state is IDLE.
- IDLE: fetch_valid=0. Goes to FETCH on run=1.
- FETCH: fetch_valid=1. On a handshake (fetch_valid & fetch_ready) with no redirect, pc <= inc_i. Without a handshake and without a redirect, pc and fetch_addr hold stable.
- Redirect priority, from highest: ret_en, call_en, branch_en. A redirect is honoured in FETCH or HOLD whether or not a handshake occurs, and sets pc to its target on the next edge. A handshake in the redirect cycle still completes; squashing that instruction is the consumer's job.
- stall=1 in FETCH: go to HOLD. HOLD keeps fetch_valid=0 and returns to FETCH when stall=0.
- halt=1 in any state other than IDLE: go to HALT, fetch_valid=0. halt has priority over stall and redirects in the same cycle. HALT is left only by reset.
- Arithmetic is 8-bit modulo and comes from the Adder. When the PC advances from 8'hFF to 8'h00, wrap_o is set.
- Reset values: pc_o=RESET_PC, fetch_valid=0, wrap_o=0, ras_err=0, stack empty.
- Reset mid-operation (rst_n low asynchronously) aborts any offer immediately and clears all state.

## Timing
- Redirect or handshake at edge N: the new fetch_addr is visible after edge N (1-cycle latency).
- fetch_valid is a registered state decode; there is no combinational path from fetch_ready to fetch_valid.
- inc_i must settle within one cycle of pc_o.
- run→first fetch_valid: 1 cycle. stall→fetch_valid low: 1 cycle.

## Configuration
- RAS_EN defined: a RAS_DEPTH-entry LIFO is compiled in.
  - call_en pushes inc_i and jumps to branch_addr.
  - ret_en pops into pc.
  - Push when full: the push is dropped, the jump still happens, and ras_err is set.
  - Pop when empty: pc <= inc_i and ras_err is set.
- RAS_EN undefined:
  - call_en behaves exactly like branch_en.
  - ret_en is ignored.
  - ras_err is tied to 0.
  - The port list is unchanged.

## Structure
- Shared package: FSM state encoding (IDLE/FETCH/HOLD/HALT), PC width constant (8), RESET_PC default.
- One sub-module: `ret_addr_stack` (push, pop, full, empty, dout, depth parameter). It is instantiated only under RAS_EN.

## Test plan
- Reset then run=1, fetch_ready=1 held: fetch_addr sequence 00,01,02,03; one address per cycle from the cycle after run.
- fetch_ready=0 for 3 cycles at PC=05: fetch_addr stays 05 with fetch_valid=1; after ready, next address is 06.
- PC=FF, handshake: PC becomes 00 and wrap_o=1, stays 1 afterwards.
- branch_en with branch_addr=40, and fetch_ready=0 in that cycle: next fetch_addr=40. Then stall=1 for 2 cycles gives fetch_valid=0, and fetch resumes at 40.
- With RAS_EN: at PC=10, call to 80; later ret_en. PC returns to 11. Five calls with RAS_DEPTH=4 set ras_err=1. Without RAS_EN, the same call jumps to 80, ret_en has no effect, and ras_err stays 0.
- halt=1 during FETCH: fetch_valid=0 the next cycle and stays low despite run or branch activity. Asserting rst_n=0 mid-offer gives fetch_valid=0 and pc_o=RESET_PC immediately.
